// File: rtl/mult_batch_host.sv
// Host-side sequencer for the leading-one approximate multiplier:
// loads operand pairs, handshakes Start/Done, streams results out.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_a/in_b        operand pair stream in (in_ready out)
//   op_we/op_addr/op_a/op_b   operand memory write port (registered)
//   Start / Done              multiplier controller handshake
//   res_addr / res_data       result RAM read port (1-cycle latency)
//   out_valid/out_data        product stream out (out_ready in)
//   batch_done                pulse after the last product is taken
//   err                       WAIT_DONE timeout pulse
//
// Optional feature: define MBH_TIMEOUT_EN to abort a batch when Done
// does not arrive within TIMEOUT cycles; otherwise err is tied 0.

module mult_batch_host #(
  parameter int DW      = 16,
  parameter int RW      = 32,
  parameter int PAIRS   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          in_ready,
  output logic          op_we,
  output logic [AW-1:0] op_addr,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic          Start,
  input  logic          Done,
  output logic [AW-1:0] res_addr,
  input  logic [RW-1:0] res_data,
  output logic          out_valid,
  output logic [RW-1:0] out_data,
  input  logic          out_ready,
  output logic          batch_done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START_HI,
    S_START_LO,
    S_WAIT,
    S_RD,
    S_CAP,
    S_SEND
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(PAIRS - 1);

  state_t        state;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] rcnt;

`ifdef MBH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
`endif

  assign in_ready = (state == S_LOAD);
  // The result RAM registers the address itself, so rcnt is
  // presented directly and the data shows up in CAP.
  assign res_addr = rcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      rcnt       <= '0;
      op_we      <= 1'b0;
      op_addr    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      Start      <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      batch_done <= 1'b0;
      err        <= 1'b0;
`ifdef MBH_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      op_we      <= 1'b0;
      Start      <= 1'b0;
      batch_done <= 1'b0;
      err        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid) state <= S_LOAD;
        end
        S_LOAD: begin
          if (in_valid) begin
            op_we   <= 1'b1;
            op_addr <= wcnt;
            op_a    <= in_a;
            op_b    <= in_b;
            if (wcnt == LAST) begin
              wcnt  <= '0;
              state <= S_START_HI;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        S_START_HI: begin
          // Start is high for the single START_LO cycle, one cycle
          // after the final operand write.
          Start <= 1'b1;
          state <= S_START_LO;
`ifdef MBH_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        S_START_LO, S_WAIT: begin
          if (Done) begin
            state <= S_RD;
`ifdef MBH_TIMEOUT_EN
          end else if (tcnt == TLAST) begin
            err   <= 1'b1;
            wcnt  <= '0;
            rcnt  <= '0;
            state <= S_IDLE;
          end else begin
            tcnt  <= tcnt + 1'b1;
            state <= S_WAIT;
`else
          end else begin
            state <= S_WAIT;
`endif
          end
        end
        S_RD: begin
          state <= S_CAP;
        end
        S_CAP: begin
          out_data  <= res_data;
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (rcnt == LAST) begin
              rcnt       <= '0;
              batch_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              rcnt  <= rcnt + 1'b1;
              state <= S_RD;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_batch_host.sv
// Directed self-checking bench for mult_batch_host.
// Models the result RAM; checks load, Start/Done, drain, reset, timeout.

module tb_mult_batch_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_ready;
  logic        op_we;
  logic [2:0]  op_addr;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        Start;
  logic        Done = 1'b0;
  logic [2:0]  res_addr;
  logic [31:0] res_data = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        batch_done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [31:0] res_mem [8];

  mult_batch_host #(
    .DW(16), .RW(32), .PAIRS(8), .AW(3), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_ready(in_ready),
    .op_we(op_we), .op_addr(op_addr), .op_a(op_a), .op_b(op_b),
    .Start(Start), .Done(Done),
    .res_addr(res_addr), .res_data(res_data),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready),
    .batch_done(batch_done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) res_data <= res_mem[res_addr];

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({op_we, Start, out_valid, batch_done, err, in_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=000000",
               {op_we, Start, out_valid, batch_done, err, in_ready});
    end
    checks++;
    if ({op_addr, op_a, op_b, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0",
               {op_addr, op_a, op_b, out_data});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drive one batch of pairs A=i+1, B=2i+3 and check writes and Start.
  // abort: assert rst in the Start cycle; early: pulse Done there.
  task automatic run_load(input bit gaps, input bit spur,
                          input bit abort, input bit early);
    int i = 0;
    int nwe = 0;
    int nst = 0;
    int first_we = 0;
    int last_we = 0;
    for (int t = 0; t < 60 && nst == 0; t++) begin
      @(negedge clk);
      if (op_we) begin
        checks++;
        if (op_addr !== 3'(nwe) || op_a !== 16'(nwe + 1) ||
            op_b !== 16'(2 * nwe + 3)) begin
          errors++;
          $display("FAIL op_write got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                   op_addr, op_a, op_b, nwe, nwe + 1, 2 * nwe + 3);
        end
        if (nwe == 0) first_we = cyc;
        last_we = cyc;
        nwe++;
      end
      if (Start) begin
        nst++;
        start_cyc = cyc;
        checks++;
        if (nwe != 8 || cyc != last_we + 1) begin
          errors++;
          $display("FAIL start_timing got=wr%0d cyc%0d exp=wr8 cyc%0d",
                   nwe, cyc, last_we + 1);
        end
      end
      Done = spur && (t == 6);
      in_valid = (i < 8) && !(gaps && (t % 3 == 2 || t % 5 == 4));
      in_a = 16'(i + 1);
      in_b = 16'(2 * i + 3);
      if (in_valid && in_ready) i++;
    end
    in_valid = 1'b0;
    Done = 1'b0;
    checks++;
    if (nst != 1) begin
      errors++;
      $display("FAIL start_seen got=%0d exp=1", nst);
    end
    if (!gaps) begin
      checks++;
      if (last_we - first_we != 7) begin
        errors++;
        $display("FAIL we_burst got=%0d exp=7", last_we - first_we);
      end
    end
    if (abort) begin
      rst = 1'b1;
      #1;
      checks++;
      if ({Start, out_valid, op_we} !== 3'b000) begin
        errors++;
        $display("FAIL async_rst got=%b exp=000",
                 {Start, out_valid, op_we});
      end
      @(negedge clk);
      rst = 1'b0;
    end else begin
      Done = early;
      @(negedge clk);
      Done = 1'b0;
      checks++;
      if (Start !== 1'b0) begin
        errors++;
        $display("FAIL start_width got=%b exp=0", Start);
      end
    end
  endtask

  task automatic send_done(input int delay);
    while (cyc < start_cyc + delay) @(negedge clk);
    Done = 1'b1;
    @(negedge clk);
    Done = 1'b0;
  endtask

  // Collect 8 products; toggle=1 gives out_ready one cycle in three.
  task automatic drain(input bit toggle);
    int k = 0;
    int nbd = 0;
    int prev = 0;
    bit held = 1'b0;
    logic [31:0] hd = '0;
    for (int t = 0; t < 150 && nbd == 0; t++) begin
      @(negedge clk);
      if (batch_done) begin
        nbd++;
        checks++;
        if (k != 8) begin
          errors++;
          $display("FAIL batch_done_early got=%0d exp=8", k);
        end
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hd) begin
          errors++;
          $display("FAIL hold got=%b/%0d exp=1/%0d", out_valid, out_data, hd);
        end
      end
      out_ready = toggle ? (t % 3 == 0) : 1'b1;
      held = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 32'(k * 100)) begin
          errors++;
          $display("FAIL product got=%0d exp=%0d", out_data, k * 100);
        end
        if (!toggle && k > 0) begin
          checks++;
          if (cyc - prev != 3) begin
            errors++;
            $display("FAIL spacing got=%0d exp=3", cyc - prev);
          end
        end
        prev = cyc;
        k++;
      end else if (out_valid) begin
        held = 1'b1;
        hd = out_data;
      end
    end
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (batch_done) nbd++;
      if (out_valid) k++;
    end
    out_ready = 1'b0;
    checks++;
    if (k != 8 || nbd != 1) begin
      errors++;
      $display("FAIL drain_count got=%0d/%0d exp=8/1", k, nbd);
    end
  endtask

  task automatic test_load_and_results();
    run_load(1'b0, 1'b0, 1'b0, 1'b0);
    send_done(20);
    drain(1'b0);
  endtask

  task automatic test_backpressure();
    run_load(1'b0, 1'b0, 1'b0, 1'b1);
    drain(1'b1);
  endtask

  task automatic test_gaps_spurious_done();
    run_load(1'b1, 1'b1, 1'b0, 1'b0);
    send_done(10);
    drain(1'b0);
  endtask

  task automatic test_reset_mid_batch();
    int bad = 0;
    run_load(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({Start, out_valid, op_we} !== 3'b000) begin
      errors++;
      $display("FAIL wait_rst got=%b exp=000", {Start, out_valid, op_we});
    end
    @(negedge clk);
    rst = 1'b0;
    Done = 1'b1;
    @(negedge clk);
    Done = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid || in_ready || Start) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_rst_idle got=%0d exp=0", bad);
    end
    run_load(1'b0, 1'b0, 1'b1, 1'b0);
    test_load_and_results();
  endtask

`ifdef MBH_TIMEOUT_EN
  task automatic test_timeout();
    int nerr = 0;
    int ecyc = 0;
    int nov = 0;
    run_load(1'b0, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 90; t++) begin
      @(negedge clk);
      if (err) begin
        nerr++;
        ecyc = cyc;
      end
      if (out_valid) nov++;
    end
    checks++;
    if (nerr != 1 || ecyc != start_cyc + 64) begin
      errors++;
      $display("FAIL timeout got=%0d@%0d exp=1@%0d",
               nerr, ecyc, start_cyc + 64);
    end
    checks++;
    if (nov != 0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle got=%0d/%b exp=0/0", nov, in_ready);
    end
    test_load_and_results();
  endtask
`else
  task automatic test_timeout();
    int bad = 0;
    run_load(1'b0, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 150; t++) begin
      @(negedge clk);
      if (err || out_valid) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_timeout got=%0d exp=0", bad);
    end
    send_done(160);
    drain(1'b0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) res_mem[i] = 32'(i * 100);
    test_reset();
    test_load_and_results();
    test_backpressure();
    test_gaps_spurious_done();
    test_reset_mid_batch();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
